// File: rtl/data_memory_responder.sv
// data_memory_responder: load/store responder with programmable wait states.
// Word-organised data memory with byte/half/word access selected by funct3.
// Optional build macro DATA_MEM_ERR_EN enables misalignment/range/funct3 error
// reporting with store suppression; without it, err_o stays 0, sub-word
// addresses are ignored by wider accesses, and the word index wraps.
module data_memory_responder #(
  parameter int unsigned DATA_MEMORY_DEPTH = 128,
  parameter int unsigned WAIT_STATES       = 1,
  parameter logic [31:0] BASE_ADDR         = 32'h1001_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic [31:0] rdata_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int unsigned IDX_W = (DATA_MEMORY_DEPTH > 1) ? $clog2(DATA_MEMORY_DEPTH) : 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DATA_MEMORY_DEPTH];

  // Fields of the transaction in flight: live inputs while accepting, latched after
  logic        acc_we;
  logic [2:0]  acc_f3;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [IDX_W-1:0] acc_idx;
  logic [1:0]  acc_lane;
  logic [31:0] acc_word;
  logic [31:0] load_data;
  logic        f3_ok;
  logic        err_c;

  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wd;

  logic        ready_d;
  logic [31:0] rdata_d;
  logic        busy_d;
  logic        err_d;

  function automatic logic [31:0] load_format(input logic [31:0] w,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    r = '0;
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'd0, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'd0, h};
      F3_W:    r = w;
      default: r = '0;
    endcase
    return r;
  endfunction

  // State and wait-counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: accept in IDLE, count WAIT_STATES cycles, one RESP cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          cnt_d   = '0;
          state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == WAIT_LAST) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture on acceptance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q     <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (state_q == ST_IDLE && req_i) begin
      we_q     <= we_i;
      funct3_q <= funct3_i;
      addr_q   <= addr_i;
      wdata_q  <= wdata_i;
    end
  end

  // Address decode, load formatting and error detection for the current access
  always_comb begin
    acc_we    = (state_q == ST_IDLE) ? we_i     : we_q;
    acc_f3    = (state_q == ST_IDLE) ? funct3_i : funct3_q;
    acc_addr  = (state_q == ST_IDLE) ? addr_i   : addr_q;
    acc_wdata = (state_q == ST_IDLE) ? wdata_i  : wdata_q;
    acc_idx   = IDX_W'((acc_addr - BASE_ADDR) >> 2);
    acc_lane  = acc_addr[1:0];
    acc_word  = mem[acc_idx];
    load_data = load_format(acc_word, acc_f3, acc_lane);
    f3_ok     = (acc_f3 == F3_B) || (acc_f3 == F3_H) || (acc_f3 == F3_W) ||
                (acc_f3 == F3_BU) || (acc_f3 == F3_HU);
`ifdef DATA_MEM_ERR_EN
    err_c = !f3_ok ||
            (((acc_f3 == F3_H) || (acc_f3 == F3_HU)) && acc_lane[0]) ||
            ((acc_f3 == F3_W) && (acc_lane != 2'b00)) ||
            (acc_addr < BASE_ADDR) ||
            ((acc_addr - BASE_ADDR) >= 32'(4 * DATA_MEMORY_DEPTH));
`else
    err_c = 1'b0;
`endif
  end

  // Store lane enables and replicated write data
  always_comb begin
    mem_be = 4'b0000;
    mem_wd = acc_wdata;
    case (acc_f3[1:0])
      2'b00: begin
        mem_be = 4'b0001 << acc_lane;
        mem_wd = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        mem_be = acc_lane[1] ? 4'b1100 : 4'b0011;
        mem_wd = {2{acc_wdata[15:0]}};
      end
      2'b10: begin
        mem_be = 4'b1111;
        mem_wd = acc_wdata;
      end
      default: mem_be = 4'b0000;
    endcase
    mem_we = (state_q == ST_RESP) && acc_we && f3_ok && !err_c;
  end

  // Memory array: store commits on the edge that ends RESP
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (mem_be[0]) mem[acc_idx][7:0]   <= mem_wd[7:0];
      if (mem_be[1]) mem[acc_idx][15:8]  <= mem_wd[15:8];
      if (mem_be[2]) mem[acc_idx][23:16] <= mem_wd[23:16];
      if (mem_be[3]) mem[acc_idx][31:24] <= mem_wd[31:24];
    end
  end

  // Output next values: response fields only for the cycle spent in RESP
  always_comb begin
    ready_d = 1'b0;
    rdata_d = '0;
    err_d   = 1'b0;
    busy_d  = (state_d != ST_IDLE);
    if (state_d == ST_RESP) begin
      ready_d = 1'b1;
      err_d   = err_c;
      rdata_d = (!acc_we && !err_c) ? load_data : 32'd0;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_o <= 1'b0;
      rdata_o <= '0;
      busy_o  <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      ready_o <= ready_d;
      rdata_o <= rdata_d;
      busy_o  <= busy_d;
      err_o   <= err_d;
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: table of load/store vectors on a
// WAIT_STATES=1 instance with a scoreboard on ready_o, plus hand sequences for
// back-to-back requests (WAIT_STATES=0 instance) and reset mid-transaction.
module tb_data_memory_responder;

`ifdef DATA_MEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam logic [31:0] B = 32'h1001_0000;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        req1 = 1'b0, we1 = 1'b0;
  logic [2:0]  f31 = '0;
  logic [31:0] addr1 = '0, wdata1 = '0;
  logic        ready1, busy1, err1;
  logic [31:0] rdata1;

  logic        req0 = 1'b0, we0 = 1'b0;
  logic [2:0]  f30 = '0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic        ready0, busy0, err0;
  logic [31:0] rdata0;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  data_memory_responder #(.DATA_MEMORY_DEPTH(128), .WAIT_STATES(1), .BASE_ADDR(B)) dut1 (
    .clk(clk), .reset(reset), .req_i(req1), .we_i(we1), .funct3_i(f31),
    .addr_i(addr1), .wdata_i(wdata1), .ready_o(ready1), .rdata_o(rdata1),
    .busy_o(busy1), .err_o(err1)
  );

  data_memory_responder #(.DATA_MEMORY_DEPTH(128), .WAIT_STATES(0), .BASE_ADDR(B)) dut0 (
    .clk(clk), .reset(reset), .req_i(req0), .we_i(we0), .funct3_i(f30),
    .addr_i(addr0), .wdata_i(wdata0), .ready_o(ready0), .rdata_o(rdata0),
    .busy_o(busy0), .err_o(err0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] er, input logic ee);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  // Scoreboard: every response of the WAIT_STATES=1 instance is popped and compared
  always @(negedge clk) begin
    if (reset && ready1 === 1'b1) begin
      chk("sb_response_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_rdata", rdata1, e.rdata);
        chk("sb_err", 32'(err1), 32'(e.err));
      end
    end
  end

  // One transaction on dut1 with latency and busy-window checks
  task automatic txn(input vec_t v);
    exp_t e;
    int lat, bcnt;
    @(negedge clk);
    req1 = 1'b1; we1 = v.we; f31 = v.f3; addr1 = v.addr; wdata1 = v.wdata;
    @(posedge clk);
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    exp_q.push_back(e);
    lat = 0;
    bcnt = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) req1 = 1'b0;
      if (busy1 === 1'b1) bcnt++;
      if (ready1 === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk("latency", 32'(lat), 32'd2);
    chk("busy_cycles", 32'(bcnt), 32'd2);
    @(negedge clk);
    chk("ready_drop", 32'(ready1), 32'd0);
    chk("busy_drop", 32'(busy1), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[23];
    int pulses, pattern_bad, extra;

    vecs[0]  = mk(1, 3'b010, B + 32'h4, 32'hDEADBEEF, 32'h0, 0);
    vecs[1]  = mk(0, 3'b010, B + 32'h4, 32'h0, 32'hDEADBEEF, 0);
    vecs[2]  = mk(1, 3'b000, B + 32'h5, 32'h12345680, 32'h0, 0);
    vecs[3]  = mk(0, 3'b000, B + 32'h5, 32'h0, 32'hFFFFFF80, 0);
    vecs[4]  = mk(0, 3'b100, B + 32'h5, 32'h0, 32'h00000080, 0);
    vecs[5]  = mk(0, 3'b010, B + 32'h4, 32'h0, 32'hDEAD80EF, 0);
    vecs[6]  = mk(1, 3'b010, B + 32'h0, 32'h11223344, 32'h0, 0);
    vecs[7]  = mk(1, 3'b001, B + 32'h2, 32'hABCD8001, 32'h0, 0);
    vecs[8]  = mk(0, 3'b001, B + 32'h2, 32'h0, 32'hFFFF8001, 0);
    vecs[9]  = mk(0, 3'b101, B + 32'h2, 32'h0, 32'h00008001, 0);
    vecs[10] = mk(0, 3'b010, B + 32'h0, 32'h0, 32'h80013344, 0);
    vecs[11] = mk(0, 3'b000, B + 32'h6, 32'h0, 32'hFFFFFFAD, 0);
    vecs[12] = mk(0, 3'b100, B + 32'h7, 32'h0, 32'h000000DE, 0);
    vecs[13] = mk(0, 3'b001, B + 32'h4, 32'h0, 32'hFFFF80EF, 0);
    vecs[14] = mk(0, 3'b101, B + 32'h6, 32'h0, 32'h0000DEAD, 0);
    vecs[15] = mk(0, 3'b011, B + 32'h4, 32'h0, 32'h0, ERR_EN);
    vecs[16] = mk(1, 3'b110, B + 32'h4, 32'h0, 32'h0, ERR_EN);
    vecs[17] = mk(0, 3'b010, B + 32'h4, 32'h0, 32'hDEAD80EF, 0);
    vecs[18] = mk(1, 3'b010, B + 32'h8, 32'h0BADF00D, 32'h0, 0);
    vecs[19] = mk(0, 3'b010, B + 32'h2, 32'h0, ERR_EN ? 32'h0 : 32'h80013344, ERR_EN);
    vecs[20] = mk(1, 3'b010, B + 32'h200, 32'hCAFEF00D, 32'h0, ERR_EN);
    vecs[21] = mk(0, 3'b010, B + 32'h0, 32'h0, ERR_EN ? 32'h80013344 : 32'hCAFEF00D, 0);
    vecs[22] = mk(0, 3'b001, B + 32'h1, 32'h0, ERR_EN ? 32'h0 : 32'hFFFFF00D, ERR_EN);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready1), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_rdata", rdata1, 32'd0);
    chk("rst_err", 32'(err1), 32'd0);
    chk("rst_busy0", 32'(busy0), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 23; i++) txn(vecs[i]);

    // Back-to-back with request held high on the zero-wait instance
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; f30 = 3'b010; addr0 = B + 32'h10; wdata0 = 32'h5A5A1234;
    @(negedge clk);
    req0 = 1'b0;
    chk("ws0_store_ready", 32'(ready0), 32'd1);
    chk("ws0_store_busy", 32'(busy0), 32'd1);
    @(negedge clk);
    chk("ws0_store_idle", 32'(ready0), 32'd0);
    req0 = 1'b1; we0 = 1'b0;
    pulses = 0;
    pattern_bad = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ready0 === 1'b1) begin
        pulses++;
        chk("ws0_load_rdata", rdata0, 32'h5A5A1234);
      end
      if (ready0 !== ((k % 2) == 1)) pattern_bad++;
      if (k == 10) req0 = 1'b0;
    end
    chk("ws0_pulses", 32'(pulses), 32'd5);
    chk("ws0_pattern", 32'(pattern_bad), 32'd0);
    extra = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (ready0 === 1'b1) extra++;
    end
    chk("ws0_no_duplicate", 32'(extra), 32'd0);

    // Reset during WAIT aborts a store
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; f31 = 3'b010; addr1 = B + 32'h8; wdata1 = 32'h12345678;
    @(negedge clk);
    req1 = 1'b0;
    chk("abort_in_wait", 32'(busy1), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy1), 32'd0);
    chk("abort_ready", 32'(ready1), 32'd0);
    chk("abort_rdata", rdata1, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    txn(mk(0, 3'b010, B + 32'h8, 32'h0, 32'h0BADF00D, 0));

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
